// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite widths, response codes and helpers
package axi_lite_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int ID_W   = 4;
   localparam int STRB_W = 4;

   typedef enum logic [1:0] {
      OKAY   = 2'b00,
      EXOKAY = 2'b01,
      SLVERR = 2'b10,
      DECERR = 2'b11
   } resp_t;

   // Decode errors are always reported as SLVERR by this responder
   function automatic resp_t resp_for(input logic err);
      return err ? SLVERR : OKAY;
   endfunction

endpackage

// File: rtl/axi_lite_regbank.sv
// rtl/axi_lite_regbank.sv - register storage with byte-strobed write and async read
module axi_lite_regbank
   import axi_lite_pkg::*;
#(
   parameter int  NUM_REGS = 16,
   localparam int IDX_W    = $clog2(NUM_REGS)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              we,
   input  logic [IDX_W-1:0]  widx,
   input  logic [DATA_W-1:0] wdata,
   input  logic [STRB_W-1:0] wstrb,
   input  logic [IDX_W-1:0]  ridx,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] regs [NUM_REGS];

   // Clear on reset, otherwise update only the strobed bytes of the addressed register
   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (we) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b]) regs[widx][8*b +: 8] <= wdata[8*b +: 8];
         end
      end
   end

   assign rdata = regs[ridx];

endmodule

// File: rtl/axi_lite_slave_regfile.sv
// rtl/axi_lite_slave_regfile.sv - AXI4-Lite responder in front of a byte-strobed register bank
module axi_lite_slave_regfile
   import axi_lite_pkg::*;
#(
   parameter int          NUM_REGS  = 16,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic [ADDR_W-1:0] awaddr,
   input  logic              awvalid,
   output logic              awready,
   input  logic [ID_W-1:0]   awid,
   input  logic [3:0]        awlen,
   input  logic [2:0]        awsize,
   input  logic [1:0]        awburst,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wvalid,
   output logic              wready,
   input  logic [STRB_W-1:0] wstrb,
   input  logic [ID_W-1:0]   wid,
   input  logic              wlast,
   output logic [1:0]        bresp,
   output logic              bvalid,
   input  logic              bready,
   output logic [ID_W-1:0]   bid,
   input  logic [ADDR_W-1:0] araddr,
   input  logic              arvalid,
   output logic              arready,
   input  logic [ID_W-1:0]   arid,
   input  logic [3:0]        arlen,
   input  logic [2:0]        arsize,
   input  logic [1:0]        arburst,
   output logic [DATA_W-1:0] rdata,
   output logic              rvalid,
   input  logic              rready,
   output logic [1:0]        rresp,
   output logic [ID_W-1:0]   rid,
   output logic              rlast
);

   localparam int               IDX_W = $clog2(NUM_REGS);
   localparam logic [ADDR_W-1:0] SPAN = ADDR_W'(4 * NUM_REGS);

   logic              aw_full, w_full;
   logic [ADDR_W-1:0] aw_addr_q;
   logic [ID_W-1:0]   aw_id_q;
   logic [3:0]        aw_len_q;
   logic [2:0]        aw_size_q;
   logic [DATA_W-1:0] w_data_q;
   logic [STRB_W-1:0] w_strb_q;

   logic [ADDR_W-1:0] aw_off, ar_off;
   logic              w_err, r_err, commit;
   logic              aw_hs, w_hs, ar_hs;
   logic [DATA_W-1:0] rd_data;

   // Offsets below BASE_ADDR wrap to huge values, so one unsigned compare covers both ends
   assign aw_off = aw_addr_q - BASE_ADDR;
   assign ar_off = araddr - BASE_ADDR;
   assign w_err  = (aw_off >= SPAN) || (aw_len_q != 4'd0);
   assign r_err  = (ar_off >= SPAN) || (arlen != 4'd0);

   // Readies are held low during reset and while a B or R beat is outstanding
   assign awready = aresetn && !aw_full && !bvalid;
   assign wready  = aresetn && !w_full && !bvalid;
   assign arready = aresetn && !rvalid;

   assign aw_hs  = awvalid && awready;
   assign w_hs   = wvalid && wready;
   assign ar_hs  = arvalid && arready;
   assign commit = aw_full && w_full;

   // Write path: independent AW/W capture, commit one edge after both are held
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         aw_full   <= 1'b0;
         w_full    <= 1'b0;
         aw_addr_q <= '0;
         aw_id_q   <= '0;
         aw_len_q  <= '0;
         aw_size_q <= '0;
         w_data_q  <= '0;
         w_strb_q  <= '0;
         bvalid    <= 1'b0;
         bresp     <= OKAY;
         bid       <= '0;
      end else begin
         if (aw_hs) begin
            aw_full   <= 1'b1;
            aw_addr_q <= awaddr;
            aw_id_q   <= awid;
            aw_len_q  <= awlen;
            aw_size_q <= awsize;
         end
         if (w_hs) begin
            w_full   <= 1'b1;
            w_data_q <= wdata;
            w_strb_q <= wstrb;
         end
         if (commit) begin
            aw_full <= 1'b0;
            w_full  <= 1'b0;
            bvalid  <= 1'b1;
            bid     <= aw_id_q;
            bresp   <= resp_for(w_err);
         end else if (bvalid && bready) begin
            bvalid <= 1'b0;
         end
      end
   end

   // Read path: data is sampled on the AR edge, before any same-edge register update lands
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         rvalid <= 1'b0;
         rdata  <= '0;
         rresp  <= OKAY;
         rid    <= '0;
         rlast  <= 1'b0;
      end else if (ar_hs) begin
         rvalid <= 1'b1;
         rdata  <= r_err ? '0 : rd_data;
         rresp  <= resp_for(r_err);
         rid    <= arid;
         rlast  <= 1'b1;
      end else if (rvalid && rready) begin
         rvalid <= 1'b0;
      end
   end

   axi_lite_regbank #(
      .NUM_REGS (NUM_REGS)
   ) u_regbank (
      .clk    (aclk),
      .resetn (aresetn),
      .we     (commit && !w_err),
      .widx   (aw_off[IDX_W+1:2]),
      .wdata  (w_data_q),
      .wstrb  (w_strb_q),
      .ridx   (ar_off[IDX_W+1:2]),
      .rdata  (rd_data)
   );

   // Burst type, write ID/last and transfer sizes carry no meaning for single-beat register access
   logic unused_inputs;
   assign unused_inputs = ^{awburst, arburst, wid, wlast, aw_size_q, arsize};

endmodule

// File: tb/tb_axi_lite_slave_regfile.sv
// tb/tb_axi_lite_slave_regfile.sv - self-checking bench for axi_lite_slave_regfile
module tb_axi_lite_slave_regfile;

   localparam int          NUM_REGS = 16;
   localparam logic [31:0] BASE     = 32'h0000_0000;

   logic        aclk = 1'b0;
   logic        aresetn;
   logic [31:0] awaddr;
   logic        awvalid;
   logic        awready;
   logic [3:0]  awid;
   logic [3:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic [31:0] wdata;
   logic        wvalid;
   logic        wready;
   logic [3:0]  wstrb;
   logic [3:0]  wid;
   logic        wlast;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [3:0]  bid;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [3:0]  arid;
   logic [3:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;
   logic [1:0]  rresp;
   logic [3:0]  rid;
   logic        rlast;

   int total = 0;
   int bad   = 0;

   logic [31:0] mdl [NUM_REGS];

   always #5 aclk = ~aclk;

   axi_lite_slave_regfile #(
      .NUM_REGS  (NUM_REGS),
      .BASE_ADDR (BASE)
   ) dut (
      .aclk (aclk), .aresetn (aresetn),
      .awaddr (awaddr), .awvalid (awvalid), .awready (awready), .awid (awid),
      .awlen (awlen), .awsize (awsize), .awburst (awburst),
      .wdata (wdata), .wvalid (wvalid), .wready (wready), .wstrb (wstrb),
      .wid (wid), .wlast (wlast),
      .bresp (bresp), .bvalid (bvalid), .bready (bready), .bid (bid),
      .araddr (araddr), .arvalid (arvalid), .arready (arready), .arid (arid),
      .arlen (arlen), .arsize (arsize), .arburst (arburst),
      .rdata (rdata), .rvalid (rvalid), .rready (rready), .rresp (rresp),
      .rid (rid), .rlast (rlast)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic bit in_range(input logic [31:0] addr);
      longint off;
      off = longint'(addr) - longint'(BASE);
      return (off >= 0) && (off < 4 * NUM_REGS);
   endfunction

   function automatic int reg_of(input logic [31:0] addr);
      return int'((longint'(addr) - longint'(BASE)) / 4);
   endfunction

   function automatic logic [31:0] model_read(input logic [31:0] addr, input logic [3:0] len);
      if (!in_range(addr) || len != 4'd0) return 32'h0;
      return mdl[reg_of(addr)];
   endfunction

   task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                              input logic [3:0] strb, input logic [3:0] len);
      int i;
      if (!in_range(addr) || len != 4'd0) return;
      i = reg_of(addr);
      for (int b = 0; b < 4; b++) if (strb[b]) mdl[i][8*b +: 8] = data[8*b +: 8];
   endtask

   task automatic drive_aw(input logic v, input logic [31:0] a, input logic [3:0] id, input logic [3:0] len);
      awvalid = v; awaddr = a; awid = id; awlen = len;
   endtask

   task automatic drive_w(input logic v, input logic [31:0] d, input logic [3:0] s);
      wvalid = v; wdata = d; wstrb = s;
   endtask

   // W leads AW by gap cycles (or AW leads W when aw_first), then B held for bwait cycles
   task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input logic [3:0] id, input logic [3:0] len, input int gap,
                            input bit aw_first, input int bwait);
      logic [1:0] exp_resp;
      exp_resp = (!in_range(addr) || len != 4'd0) ? 2'b10 : 2'b00;
      @(negedge aclk);
      if (gap == 0) begin
         drive_aw(1'b1, addr, id, len);
         drive_w(1'b1, data, strb);
         check("awready_idle", 32'(awready), 32'd1);
         check("wready_idle", 32'(wready), 32'd1);
         @(negedge aclk);
         awvalid = 1'b0; wvalid = 1'b0;
      end else begin
         if (aw_first) drive_aw(1'b1, addr, id, len); else drive_w(1'b1, data, strb);
         check("first_ready", 32'(aw_first ? awready : wready), 32'd1);
         @(negedge aclk);
         awvalid = 1'b0; wvalid = 1'b0;
         repeat (gap - 1) @(negedge aclk);
         if (aw_first) drive_w(1'b1, data, strb); else drive_aw(1'b1, addr, id, len);
         check("second_ready", 32'(aw_first ? wready : awready), 32'd1);
         @(negedge aclk);
         awvalid = 1'b0; wvalid = 1'b0;
      end
      check("bvalid_commit_cycle", 32'(bvalid), 32'd0);
      @(negedge aclk);
      check("bvalid_set", 32'(bvalid), 32'd1);
      check("bresp", 32'(bresp), 32'(exp_resp));
      check("bid", 32'(bid), 32'(id));
      for (int k = 0; k < bwait; k++) begin
         check("awready_bstall", 32'(awready), 32'd0);
         check("wready_bstall", 32'(wready), 32'd0);
         @(negedge aclk);
         check("bvalid_stable", 32'(bvalid), 32'd1);
         check("bresp_stable", 32'(bresp), 32'(exp_resp));
         check("bid_stable", 32'(bid), 32'(id));
      end
      bready = 1'b1;
      @(negedge aclk);
      bready = 1'b0;
      check("bvalid_clear", 32'(bvalid), 32'd0);
      check("awready_after_b", 32'(awready), 32'd1);
      model_write(addr, data, strb, len);
   endtask

   task automatic read_txn(input logic [31:0] addr, input logic [3:0] id, input logic [3:0] len,
                           input int rwait);
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
      exp_data = model_read(addr, len);
      exp_resp = (!in_range(addr) || len != 4'd0) ? 2'b10 : 2'b00;
      @(negedge aclk);
      arvalid = 1'b1; araddr = addr; arid = id; arlen = len;
      check("arready_idle", 32'(arready), 32'd1);
      @(negedge aclk);
      arvalid = 1'b0;
      for (int k = 0; k <= rwait; k++) begin
         if (k > 0) @(negedge aclk);
         check("rvalid", 32'(rvalid), 32'd1);
         check("rdata", rdata, exp_data);
         check("rresp", 32'(rresp), 32'(exp_resp));
         check("rid", 32'(rid), 32'(id));
         check("rlast", 32'(rlast), 32'd1);
         check("arready_rstall", 32'(arready), 32'd0);
      end
      rready = 1'b1;
      @(negedge aclk);
      rready = 1'b0;
      check("rvalid_clear", 32'(rvalid), 32'd0);
      check("arready_after_r", 32'(arready), 32'd1);
   endtask

   initial begin
      logic [31:0] old4;
      aresetn = 1'b0;
      drive_aw(1'b0, 32'h0, 4'h0, 4'h0);
      drive_w(1'b0, 32'h0, 4'h0);
      awsize = 3'b010; awburst = 2'b01; wid = 4'h0; wlast = 1'b1;
      bready = 1'b0; rready = 1'b0;
      arvalid = 1'b0; araddr = 32'h0; arid = 4'h0; arlen = 4'h0;
      arsize = 3'b010; arburst = 2'b01;
      for (int i = 0; i < NUM_REGS; i++) mdl[i] = 32'h0;

      // Reset state
      repeat (2) @(negedge aclk);
      check("rst_bvalid", 32'(bvalid), 32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_awready", 32'(awready), 32'd0);
      check("rst_wready", 32'(wready), 32'd0);
      check("rst_arready", 32'(arready), 32'd0);
      check("rst_bresp", 32'(bresp), 32'd0);
      check("rst_rresp", 32'(rresp), 32'd0);
      check("rst_rdata", rdata, 32'd0);
      check("rst_bid", 32'(bid), 32'd0);
      check("rst_rid", 32'(rid), 32'd0);
      aresetn = 1'b1;
      @(negedge aclk);
      check("post_rst_awready", 32'(awready), 32'd1);
      check("post_rst_arready", 32'(arready), 32'd1);

      // Simultaneous AW/W, then read back
      write_txn(32'h4, 32'hDEAD_BEEF, 4'hF, 4'h5, 4'h0, 0, 1'b0, 0);
      read_txn(32'h4, 4'h9, 4'h0, 0);

      // W three cycles ahead of AW with partial strobes over an all-ones register
      write_txn(32'h8, 32'hFFFF_FFFF, 4'hF, 4'h1, 4'h0, 0, 1'b0, 0);
      write_txn(32'h8, 32'h1122_3344, 4'b0101, 4'h2, 4'h0, 3, 1'b0, 0);
      read_txn(32'h8, 4'h3, 4'h0, 0);
      check("partial_strobe_value", model_read(32'h8, 4'h0), 32'hFF22_FF44);

      // Out-of-range and burst-length errors, zero strobe
      write_txn(BASE + 32'(4 * NUM_REGS), 32'h1234_5678, 4'hF, 4'h7, 4'h0, 0, 1'b0, 0);
      read_txn(BASE + 32'(4 * NUM_REGS), 4'h6, 4'h0, 0);
      write_txn(32'h4, 32'h0BAD_0BAD, 4'hF, 4'h8, 4'h3, 1, 1'b1, 0);
      read_txn(32'h4, 4'hA, 4'h2, 0);
      read_txn(32'h4, 4'hB, 4'h0, 0);
      write_txn(32'hC, 32'hCAFE_F00D, 4'h0, 4'hC, 4'h0, 0, 1'b0, 0);
      read_txn(32'hC, 4'hD, 4'h0, 0);

      // B and R backpressure
      write_txn(32'h10, 32'hA5A5_5A5A, 4'hF, 4'hE, 4'h0, 2, 1'b1, 5);
      read_txn(32'h10, 4'hF, 4'h0, 4);

      // Read issued on the same edge the write to that register lands
      old4 = mdl[1];
      @(negedge aclk);
      drive_aw(1'b1, 32'h4, 4'h4, 4'h0);
      drive_w(1'b1, 32'h5555_AAAA, 4'hF);
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0;
      arvalid = 1'b1; araddr = 32'h4; arid = 4'h2; arlen = 4'h0;
      @(negedge aclk);
      arvalid = 1'b0;
      check("same_edge_bvalid", 32'(bvalid), 32'd1);
      check("same_edge_rvalid", 32'(rvalid), 32'd1);
      check("same_edge_old_data", rdata, old4);
      bready = 1'b1; rready = 1'b1;
      @(negedge aclk);
      bready = 1'b0; rready = 1'b0;
      check("same_edge_bclear", 32'(bvalid), 32'd0);
      check("same_edge_rclear", 32'(rvalid), 32'd0);
      model_write(32'h4, 32'h5555_AAAA, 4'hF, 4'h0);
      read_txn(32'h4, 4'h1, 4'h0, 0);

      // Randomized traffic against the reference model
      for (int it = 0; it < 40; it++) begin
         logic [31:0] a, ra;
         logic [3:0]  len;
         a   = BASE + 32'($urandom_range(0, NUM_REGS + 1) * 4 + $urandom_range(0, 3));
         len = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
         write_txn(a, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), len,
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
         ra = BASE + 32'($urandom_range(0, NUM_REGS + 1) * 4 + $urandom_range(0, 3));
         read_txn(ra, 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0) ? 4'h1 : 4'h0, int'($urandom_range(0, 2)));
      end

      // Reset while both B and R are pending
      @(negedge aclk);
      drive_aw(1'b1, 32'h4, 4'h3, 4'h0);
      drive_w(1'b1, 32'h7777_7777, 4'hF);
      arvalid = 1'b1; araddr = 32'h8; arid = 4'h4; arlen = 4'h0;
      @(negedge aclk);
      awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      @(negedge aclk);
      check("pre_rst_bvalid", 32'(bvalid), 32'd1);
      check("pre_rst_rvalid", 32'(rvalid), 32'd1);
      aresetn = 1'b0;
      @(negedge aclk);
      check("mid_rst_bvalid", 32'(bvalid), 32'd0);
      check("mid_rst_rvalid", 32'(rvalid), 32'd0);
      check("mid_rst_awready", 32'(awready), 32'd0);
      check("mid_rst_arready", 32'(arready), 32'd0);
      aresetn = 1'b1;
      for (int i = 0; i < NUM_REGS; i++) mdl[i] = 32'h0;
      repeat (3) begin
         @(negedge aclk);
         check("no_stray_bvalid", 32'(bvalid), 32'd0);
         check("no_stray_rvalid", 32'(rvalid), 32'd0);
      end
      for (int i = 0; i < NUM_REGS; i++) read_txn(BASE + 32'(4 * i), 4'(i), 4'h0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/axi_lite_slave_regfile.md
Name: axi_lite_slave_regfile

Overview:
- AXI4-Lite responder that terminates the write and read channels driven by the verification master.
- Holds a bank of NUM_REGS 32-bit registers with byte-strobed writes.
- Returns OKAY or SLVERR responses and echoes transaction IDs.
- Serves as the DUT behind the protocol interface, so every interface stability check applies to its B and R outputs.

Parameters:
- NUM_REGS, 16, number of 32-bit registers; power of two, minimum 2.
- BASE_ADDR, 32'h0000_0000, byte address of register 0. In-range window is BASE_ADDR .. BASE_ADDR+4*NUM_REGS-1.

Ports:
- aclk  in  1  clock. One clock domain; reset is synchronous, active-low.
- aresetn  in  1  synchronous active-low reset.
- awaddr in 32; awvalid in 1; awready out 1; awid in 4; awlen in 4; awsize in 3; awburst in 2.
- wdata in 32; wvalid in 1; wready out 1; wstrb in 4; wid in 4; wlast in 1.
- bresp out 2; bvalid out 1; bready in 1; bid out 4.
- araddr in 32; arvalid in 1; arready out 1; arid in 4; arlen in 4; arsize in 3; arburst in 2.
- rdata out 32; rvalid out 1; rready in 1; rresp out 2; rid out 4; rlast out 1.

Behaviour:
- Reset (aresetn low at a posedge): all ready/valid outputs 0, bresp, rresp, rdata, bid and rid 0, registers 0, pending captures dropped.
  - Applies mid-transaction: a held bvalid or rvalid drops the cycle after reset and is never re-issued.
- Write path uses independent AW and W capture flags, aw_full and w_full.
  - awready = !aw_full && !bvalid; wready = !w_full && !bvalid.
  - On awvalid&&awready, latch awaddr, awid, awlen and awsize, and set aw_full.
  - On wvalid&&wready, latch wdata and wstrb, and set w_full.
  - AW and W may handshake in the same cycle or in either order, any number of cycles apart.
- Write commit happens at the first edge where both flags are set, counting flags set on that same edge.
  - The register update is applied one edge later, together with bvalid=1, bid=latched awid and bresp. Both flags clear on that edge.
  - Latency: simultaneous AW/W handshake at edge N gives the register update and bvalid at edge N+1.
- Write response:
  - bresp = SLVERR (2'b10) if the address is out of range or awlen != 0; no register is modified.
  - Otherwise bresp = OKAY (2'b00), and byte i of the register is written only when wstrb[i]=1.
  - wstrb = 0 gives OKAY with no change.
  - The register index is taken from addr bits [log2(NUM_REGS)+1:2]; addr[1:0] is ignored.
- bvalid, bresp and bid stay stable until bready is sampled high; bvalid clears on that edge. No new AW/W is accepted while bvalid=1.
- Read path:
  - arready = !rvalid.
  - On arvalid&&arready at edge N, assert rvalid at edge N+1 with rid=arid and rlast=1.
  - Decode: out-of-range or arlen != 0 gives rresp=SLVERR and rdata=0. Otherwise rresp=OKAY and rdata = register value as of edge N.
  - A write committing on edge N is not visible; the read returns the old value.
- rvalid, rdata, rresp and rid stay stable until rready is sampled high; rvalid clears on that edge.
  - arready returns high the cycle after the R handshake, so back-to-back reads run every 2 cycles.
- Read and write paths are fully independent and may complete in the same cycle.
- awburst, arburst, wid and wlast are ignored. awsize and arsize are not checked.

Decomposition:
- Shared package axi_lite_pkg:
  - resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - Constants DATA_W=32, ADDR_W=32, ID_W=4, STRB_W=4.
- One sub-module, axi_lite_regbank:
  - NUM_REGS x 32 storage, one byte-strobed write port and one combinational read port.
  - Write enable is suppressed on decode error.
- FSMs and handshake logic live in the top module.

Test Plan:
- Reset, then simultaneous AW/W to addr 0x4, data 0xDEADBEEF, wstrb 4'hF, bready=1 -> bvalid at the next edge, bresp=OKAY, bid=awid; a read of 0x4 returns 0xDEADBEEF with rresp=OKAY and rlast=1.
- W presented 3 cycles before AW (addr 0x8, data 0x11223344, wstrb 4'b0101) over a reg holding 0xFFFFFFFF -> one B response; a read returns 0xFF22FF44.
- Write to BASE_ADDR+4*NUM_REGS -> bresp=SLVERR and no register changes; a read there -> rresp=SLVERR, rdata=0.
- bready held low 5 cycles after bvalid -> bvalid, bresp and bid stable; awready and wready stay 0; a new AW is accepted only the cycle after the B handshake.
- rready held low 4 cycles -> rvalid, rdata and rresp stable; arready=0 throughout. Same-edge read of 0x4 during a write commit to 0x4 -> returns the old value.
- aresetn pulsed low while bvalid=1 and rvalid=1 -> both 0 the next cycle, all registers read back 0, no stray response issued.
